muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Parametrised control sequencer for the M-extension multi-cycle multiply/divide datapath. It accepts one operation at a time through a valid/ready request port and starts the datapath. It counts an operation-specific latency and holds a response until the writeback stage takes it. It supports back-to-back issue, a divide-by-zero early exit and pipeline flush. It sits between the execute-stage issue logic and the multiplier/divider datapaths.

## Interface
Parameters:
- MUL_LAT, 4, cycles from request acceptance to resp_valid for multiply ops (legal range ≥ 2)
- DIV_LAT, 33, cycles from request acceptance to resp_valid for divide/remainder ops (legal range ≥ 2)
- TAG_W, 5, width of the destination tag carried with the op

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  issue stage presents an op
- req_ready  out  1  sequencer can accept this cycle
- req_is_div  in  1  1 = div/rem, 0 = mul
- req_div_zero  in  1  divisor is zero (only meaningful when req_is_div)
- req_funct3  in  3  RISC-V funct3 of the op
- req_tag  in  TAG_W  destination tag
- flush  in  1  kill any in-flight or pending op
- unit_start  out  1  one-cycle start pulse to datapath
- unit_is_div  out  1  selects divider datapath; valid while busy
- busy  out  1  state != IDLE
- resp_valid  out  1  result ready
- resp_ready  in  1  writeback consumes result
- resp_funct3  out  3  latched funct3
- resp_tag  out  TAG_W  latched tag

## Operation
- States: IDLE, RUN, DONE.
- req_ready = !rst & !flush & (state==IDLE | (state==DONE & resp_ready)).
- Accept = req_valid & req_ready. On accept: latch funct3, tag and is_div. unit_start = accept, which is combinational and falls in the same cycle.
- Accept with req_is_div & req_div_zero → next state DONE. The counter is not used.
- Any other accept → next state RUN, with cnt loaded to L−2, where L = DIV_LAT if is_div else MUL_LAT.
- RUN: if cnt==0, next state DONE; else cnt decrements.
- DONE: resp_valid=1, held until resp_ready.
  - resp_ready & accept → the new op follows the accept rules above, giving back-to-back issue with no IDLE bubble.
  - resp_ready & !accept → IDLE.
- flush (any state) → next state IDLE. resp_valid is forced 0 in the flush cycle. No accept happens that cycle. A response in DONE is discarded even if resp_ready=1.
- rst has priority over flush and everything else.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)). The counter never wraps: it is only decremented when nonzero.

## Timing
- Reset values: state IDLE, cnt 0, resp_funct3 0, resp_tag 0, unit_is_div 0.
- Outputs during the reset cycle: req_ready 0, resp_valid 0, busy 0, unit_start 0.
- Normal latency: accept in cycle 0 → resp_valid first high in cycle L.
- Divide-by-zero: resp_valid high in cycle 1.
- Throughput with resp_ready tied high: one op per L cycles.
- The resp_* fields are stable while resp_valid=1 and !resp_ready.
- Reset or flush mid-RUN: busy low and req_ready high in the following cycle. No stale resp_valid is produced later.

## Structure
- Package m_extension holds:
  - the muldiv_state_e enum (IDLE, RUN, DONE)
  - default latency constants MUL_LAT_DEF and DIV_LAT_DEF
  - funct3 localparams (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- Sub-module latency_counter: parametrised down-counter with load/load_val/dec inputs and an is_zero output.
- The FSM and field registers stay in muldiv_sequencer.

## Test plan
- MUL op (funct3=000, tag=7), resp_ready=1 → unit_start in cycle 0, resp_valid only in cycle 4 with resp_tag=7, busy cycles 1–4.
- DIV op, divisor nonzero, DIV_LAT=33 → resp_valid at cycle 33. req_ready stays 0 in cycles 1–32 despite req_valid held high.
- DIV with req_div_zero=1, funct3=100 → resp_valid at cycle 1, funct3=100. The next op is accepted in cycle 1.
- Backpressure: resp_ready=0 for 5 cycles after DONE → resp_valid and tag held constant. Then resp_ready=1 with a new MUL valid → accepted that same cycle, next resp_valid 4 cycles later.
- Flush at cycle 2 of a MUL → no resp_valid ever for that op, IDLE in cycle 3. Flush coincident with req_valid → op not accepted.
- Reset asserted mid-DIV (cycle 10) → resp_valid=0, busy=0 after reset. The first post-reset MUL completes in exactly 4 cycles.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// m_extension: shared types and constants for the multiply/divide sequencer
// Contents: sequencer state enum, default latencies, RISC-V M-extension funct3 codes
package m_extension;
    typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_e;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 33;
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;
endpackage

// File: rtl/muldiv_sequencer_latency_counter.sv
// latency_counter: loadable down-counter that saturates at zero
// Ports: clk, rst (sync, active-high), load_i/load_val_i load a start value,
//        dec_i decrements when nonzero, is_zero_o flags a count of zero
module latency_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign is_zero_o = (cnt_q == '0);
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: issue/latency/response control for the multi-cycle mul/div datapath
// Ports: req_* valid/ready issue port with op class, div-by-zero, funct3 and tag;
//        flush kills in-flight work; unit_start/unit_is_div drive the datapath;
//        busy reflects a non-idle sequencer; resp_* valid/ready result port
module muldiv_sequencer
    import m_extension::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_div,
    input  logic             req_div_zero,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             unit_start,
    output logic             unit_is_div,
    output logic             busy,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [2:0]       resp_funct3,
    output logic [TAG_W-1:0] resp_tag
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL);

    muldiv_state_e    state_q, state_d;
    logic [2:0]       funct3_q;
    logic [TAG_W-1:0] tag_q;
    logic             is_div_q;
    logic             accept, zero_exit, load, dec, cnt_zero;
    logic [CW-1:0]    load_val;

    latency_counter #(.W(CW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .load_val_i(load_val),
        .dec_i     (dec),
        .is_zero_o (cnt_zero)
    );

    always_comb begin
        req_ready  = !rst && !flush && (state_q == IDLE || (state_q == DONE && resp_ready));
        accept     = req_valid && req_ready;
        zero_exit  = req_is_div && req_div_zero;
        load       = accept && !zero_exit;
        dec        = (state_q == RUN);
        load_val   = req_is_div ? CW'(DIV_LAT - 2) : CW'(MUL_LAT - 2);
        unit_start = accept;
        resp_valid = !rst && !flush && state_q == DONE;
        busy       = !rst && state_q != IDLE;
        state_d    = state_q;
        if (accept)
            state_d = zero_exit ? DONE : RUN;
        else if (state_q == RUN)
            state_d = cnt_zero ? DONE : RUN;
        else if (state_q == DONE && resp_ready)
            state_d = IDLE;
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            tag_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q <= req_funct3;
                tag_q    <= req_tag;
                is_div_q <= req_is_div;
            end
        end
    end

    assign unit_is_div = is_div_q;
    assign resp_funct3 = funct3_q;
    assign resp_tag    = tag_q;
endmodule
